// File: rtl/counter_checker.sv
// counter_checker
//   Receive-side checker for a free-running up-counter. Watches a WIDTH-bit
//   count stream and confirms that it advances by exactly +1 (mod 2^WIDTH)
//   on every sampled cycle. It locks onto the stream and flags sequence
//   breaks. It also keeps saturating statistics of breaks and of valid wraps.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   synchronous active-low reset
//   en       in   sample strobe; count is evaluated only when en=1
//   count    in   [WIDTH-1:0] observed counter value
//   locked   out  high while in LOCKED
//   err      out  one-cycle pulse on a sequence break detected in LOCKED
//   err_cnt  out  [CNT_W-1:0] saturating count of sequence breaks
//   wrap_cnt out  [CNT_W-1:0] saturating count of wraps seen in LOCKED
module counter_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCKED
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic [3:0]       run, run_nxt;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_nxt;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_nxt;

  logic [WIDTH-1:0] prev_inc;
  logic [3:0]       run_inc;
  logic             match;
  logic             wrap;

  always_comb begin
    prev_inc = prev + 1'b1;
    run_inc  = run + 4'd1;
    match    = (count == prev_inc);
    wrap     = match && (prev == '1);
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      run        <= run_nxt;
      err_q      <= err_nxt;
      err_cnt_q  <= err_cnt_nxt;
      wrap_cnt_q <= wrap_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    run_nxt      = run;
    err_nxt      = 1'b0;
    err_cnt_nxt  = err_cnt_q;
    wrap_cnt_nxt = wrap_cnt_q;

    if (en) begin
      // Every sample becomes the new reference, so a re-sync after a break
      // starts from the offending value.
      prev_nxt = count;
      unique case (state)
        IDLE: begin
          run_nxt   = '0;
          state_nxt = SYNC;
        end
        SYNC: begin
          if (match) begin
            if (run_inc == 4'(LOCK_LEN)) begin
              run_nxt   = '0;
              state_nxt = LOCKED;
            end else begin
              run_nxt = run_inc;
            end
          end else begin
            run_nxt = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            if (wrap && (wrap_cnt_q != '1)) begin
              wrap_cnt_nxt = wrap_cnt_q + 1'b1;
            end
          end else begin
            err_nxt = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_nxt = err_cnt_q + 1'b1;
            end
            run_nxt   = '0;
            state_nxt = SYNC;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    locked   = (state == LOCKED);
    err      = err_q;
    err_cnt  = err_cnt_q;
    wrap_cnt = wrap_cnt_q;
  end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side companion to the free-running up-counter: watches a WIDTH-bit count stream and confirms it advances by exactly +1 (mod 2^WIDTH) on every sampled cycle.
- Locks onto the stream, flags sequence breaks, and keeps saturating error and wrap statistics.
- Sits downstream of any counter output, on-chip or as a synthesizable checker in benches.

Parameters:
- WIDTH, 4, bit width of the observed count.
- LOCK_LEN, 2, consecutive correct increments required to enter LOCKED (1..15).
- CNT_W, 8, width of err_cnt and wrap_cnt; both saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset; rst=0 at a rising edge resets the block.
- en  input  1  sample strobe; count is evaluated only on edges where en=1.
- count  input  WIDTH  observed counter value.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse on a sequence break detected in LOCKED.
- err_cnt  output  CNT_W  number of sequence breaks, saturating.
- wrap_cnt  output  CNT_W  number of valid wraps (2^WIDTH-1 -> 0) seen in LOCKED, saturating.

Behaviour:
- Reset (rst=0 at edge, any state, including mid-operation):
  - state=IDLE; prev=0; run=0.
  - locked=0, err=0, err_cnt=0, wrap_cnt=0.
  - rst has priority over en.
- All outputs are registered. Results for a sample appear after the edge that samples it (latency 1).
- Define match = (count == prev+1 truncated to WIDTH bits); wrap = match and prev == 2^WIDTH-1.
- en=0: state, prev, run and counters hold; err=0.
- IDLE, on en:
  - prev<=count; run<=0; go SYNC.
  - No match check is made on the first sample.
- SYNC, on en:
  - On match: run<=run+1; if run+1==LOCK_LEN go LOCKED and clear run.
  - On no match: run<=0; stay in SYNC; no err and no err_cnt change.
  - prev<=count always.
  - Wraps are not counted in SYNC.
- LOCKED, on en:
  - On match: stay in LOCKED; if wrap, wrap_cnt<=wrap_cnt+1 unless saturated.
  - On no match: err<=1 for exactly one cycle; err_cnt<=err_cnt+1 unless saturated; go SYNC with run<=0.
  - prev<=count always, so re-sync starts from the offending value.
- locked is 1 exactly while state==LOCKED. It drops on the same edge that raises err.
- Counter saturation: on reaching all-ones, further increments are ignored. Counters never wrap to 0.
- Repeated value (count==prev) is a break. A jump of +2 or more, or any backward step, is a break.
- With en toggling, only en=1 samples are compared. Gaps are not errors.

Test Plan:
- Reset, then drive en=1 with count 0,1,2,3 on successive edges -> locked=0 after samples 0 and 1, locked=1 after the edge sampling 2; err stays 0.
- Drive count 0..15 then 0..3 continuously with en=1 -> wrap_cnt=1, err_cnt=0, locked held high after lock, err never asserts.
- While locked, drive 4,5,6,8,9,10 -> err=1 for one cycle after the edge sampling 8, err_cnt=1, locked=0; locked=1 again after the edge sampling 10.
- While locked, drive 3,4 with en=1, then hold en=0 for 5 cycles with count=12, then en=1 with 5,6 -> no err, locked stays 1, counters unchanged.
- While locked with err_cnt=1 and wrap_cnt=1, assert rst=0 for one edge -> next cycle locked=0, err=0, err_cnt=0, wrap_cnt=0; the next en sample only moves the block to SYNC.
- With CNT_W=2, LOCK_LEN=1, cause 5 separate breaks, relocking between them -> err pulses 5 times, err_cnt stops at 3.
